// File: rtl/rbm_gibbs_sequencer_if.sv
// Bundle of control, result and layer-handshake signals around the RBM Gibbs sequencer.
// slave: the sequencer's view. master: the top level plus the two layer instances.
interface rbm_gibbs_sequencer_if #(
   parameter int unsigned VIS_DIM = 15,
   parameter int unsigned HID_DIM = 5,
   parameter int unsigned STEP_W  = 8
);
   logic               start;
   logic [STEP_W-1:0]  num_steps;
   logic [VIS_DIM-1:0] v_in;
   logic               busy;
   logic               done;
   logic               error;
   logic [VIS_DIM-1:0] v_out;
   logic [HID_DIM-1:0] h_out;
   logic [HID_DIM-1:0] h0_out;
   logic               rand_reset;
   logic               h_layer_reset;
   logic               v_layer_reset;
   logic               h_data_valid;
   logic               v_data_valid;
   logic [VIS_DIM-1:0] h_input;
   logic [HID_DIM-1:0] v_input;
   logic [HID_DIM-1:0] h_output;
   logic               h_finish;
   logic [VIS_DIM-1:0] v_output;
   logic               v_finish;

   modport slave (
      input  start, num_steps, v_in, h_output, h_finish, v_output, v_finish,
      output busy, done, error, v_out, h_out, h0_out, rand_reset,
             h_layer_reset, v_layer_reset, h_data_valid, v_data_valid, h_input, v_input
   );

   modport master (
      output start, num_steps, v_in, h_output, h_finish, v_output, v_finish,
      input  busy, done, error, v_out, h_out, h0_out, rand_reset,
             h_layer_reset, v_layer_reset, h_data_valid, v_data_valid, h_input, v_input
   );
endinterface

// File: rtl/rbm_gibbs_sequencer.sv
// k-step Gibbs sampling controller alternating a hidden and a visible RBM layer.
// Optional per-phase watchdog: define RBM_SEQ_TIMEOUT_EN to enable it (error tied 0 otherwise).
module rbm_gibbs_sequencer #(
   parameter int unsigned VIS_DIM = 15,
   parameter int unsigned HID_DIM = 5,
   parameter int unsigned STEP_W  = 8,
   parameter int unsigned TIMEOUT = 4095
) (
   input  logic                 clock,
   input  logic                 reset,
   rbm_gibbs_sequencer_if.slave bus
);
   typedef enum logic [2:0] {S_IDLE, S_SEED, S_H_RUN, S_V_RUN, S_DONE} state_e;

   state_e             state_q, state_d;
   logic [VIS_DIM-1:0] v_reg_q, v_reg_d;
   logic [HID_DIM-1:0] h_reg_q, h_reg_d;
   logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;
   logic               first_q, first_d;
   logic [VIS_DIM-1:0] v_out_q, v_out_d;
   logic [HID_DIM-1:0] h_out_q, h_out_d;
   logic [HID_DIM-1:0] h0_out_q, h0_out_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               rand_reset_q, rand_reset_d;
   logic               h_rst_q, h_rst_d;
   logic               v_rst_q, v_rst_d;
   logic               h_dv_q, h_dv_d;
   logic               v_dv_q, v_dv_d;

`ifdef RBM_SEQ_TIMEOUT_EN
   localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
   logic            error_q, error_d;
`endif

   // Next-state, datapath captures and next values of the registered outputs.
   always_comb begin
      state_d    = state_q;
      v_reg_d    = v_reg_q;
      h_reg_d    = h_reg_q;
      step_cnt_d = step_cnt_q;
      first_d    = first_q;
      v_out_d    = v_out_q;
      h_out_d    = h_out_q;
      h0_out_d   = h0_out_q;
`ifdef RBM_SEQ_TIMEOUT_EN
      wd_cnt_d   = wd_cnt_q;
      error_d    = error_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d    = S_SEED;
               v_reg_d    = bus.v_in;
               step_cnt_d = (bus.num_steps == '0) ? STEP_W'(1) : bus.num_steps;
               first_d    = 1'b1;
               h_out_d    = '0;
               h0_out_d   = '0;
`ifdef RBM_SEQ_TIMEOUT_EN
               error_d    = 1'b0;
`endif
            end
         end
         S_SEED: state_d = S_H_RUN;
         S_H_RUN: begin
            if (bus.h_finish) begin
               h_reg_d = bus.h_output;
               h_out_d = bus.h_output;
               if (first_q) h0_out_d = bus.h_output;
               first_d = 1'b0;
               state_d = S_V_RUN;
            end
         end
         S_V_RUN: begin
            if (bus.v_finish) begin
               v_reg_d    = bus.v_output;
               step_cnt_d = step_cnt_q - STEP_W'(1);
               if (step_cnt_q == STEP_W'(1)) begin
                  // Present the reconstruction together with the done pulse.
                  v_out_d = bus.v_output;
                  state_d = S_DONE;
               end else begin
                  state_d = S_H_RUN;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
`ifdef RBM_SEQ_TIMEOUT_EN
      // Watchdog: abandon a run phase whose layer never reports finish.
      if ((state_q == S_H_RUN && !bus.h_finish) || (state_q == S_V_RUN && !bus.v_finish)) begin
         if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
            error_d = 1'b1;
            state_d = S_IDLE;
         end else begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
         end
      end
      if (state_d != state_q) wd_cnt_d = '0;
`endif
      // Outputs are registered from the next state so they line up with it.
      busy_d       = (state_d != S_IDLE);
      done_d       = (state_d == S_DONE);
      rand_reset_d = (state_d == S_SEED);
      h_rst_d      = (state_d != S_H_RUN);
      v_rst_d      = (state_d != S_V_RUN);
      h_dv_d       = (state_d == S_H_RUN);
      v_dv_d       = (state_d == S_V_RUN);
   end

   // State and output registers; layers stay in reset while the block is in reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         v_reg_q      <= '0;
         h_reg_q      <= '0;
         step_cnt_q   <= '0;
         first_q      <= 1'b0;
         v_out_q      <= '0;
         h_out_q      <= '0;
         h0_out_q     <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         rand_reset_q <= 1'b1;
         h_rst_q      <= 1'b1;
         v_rst_q      <= 1'b1;
         h_dv_q       <= 1'b0;
         v_dv_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         v_reg_q      <= v_reg_d;
         h_reg_q      <= h_reg_d;
         step_cnt_q   <= step_cnt_d;
         first_q      <= first_d;
         v_out_q      <= v_out_d;
         h_out_q      <= h_out_d;
         h0_out_q     <= h0_out_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         rand_reset_q <= rand_reset_d;
         h_rst_q      <= h_rst_d;
         v_rst_q      <= v_rst_d;
         h_dv_q       <= h_dv_d;
         v_dv_q       <= v_dv_d;
      end
   end

`ifdef RBM_SEQ_TIMEOUT_EN
   // Watchdog counter and sticky error flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wd_cnt_q <= '0;
         error_q  <= 1'b0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
         error_q  <= error_d;
      end
   end
   assign bus.error = error_q;
`else
   assign bus.error = 1'b0;
`endif

   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.v_out         = v_out_q;
   assign bus.h_out         = h_out_q;
   assign bus.h0_out        = h0_out_q;
   assign bus.rand_reset    = rand_reset_q;
   assign bus.h_layer_reset = h_rst_q;
   assign bus.v_layer_reset = v_rst_q;
   assign bus.h_data_valid  = h_dv_q;
   assign bus.v_data_valid  = v_dv_q;
   assign bus.h_input       = v_reg_q;
   assign bus.v_input       = h_reg_q;
endmodule

// File: tb/tb_rbm_gibbs_sequencer.sv
// Bench for rbm_gibbs_sequencer: stub layers with programmable latency and outputs,
// expectations computed from the sampling rules (latency formula, value routing per step).
module tb_rbm_gibbs_sequencer;
   logic clock = 1'b0;
   logic reset;

   rbm_gibbs_sequencer_if #(.VIS_DIM(15), .HID_DIM(5), .STEP_W(8)) bus ();

   rbm_gibbs_sequencer #(.VIS_DIM(15), .HID_DIM(5), .STEP_W(8), .TIMEOUT(20)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   // Stub configuration (written only by the stimulus process).
   int          lh, lv;
   bit          h_stall;
   logic [4:0]  h_vals [16];
   logic [14:0] v_vals [16];

   // Stub state and observations (written only by the stubs).
   int          h_cnt, v_cnt, h_idx, v_idx;
   logic [15:0] hin_seen [16];
   logic [15:0] vin_seen [16];

   // Hidden-layer stub: finish lh cycles after valid rises; logs the input it was given.
   always @(posedge clock) begin
      if (bus.rand_reset) begin
         h_idx <= 0;
         for (int i = 0; i < 16; i++) hin_seen[i] <= 16'hFFFF;
      end
      if (bus.h_layer_reset) begin
         h_cnt        <= 0;
         bus.h_finish <= 1'b0;
         bus.h_output <= '0;
      end else if (bus.h_data_valid && !bus.h_finish) begin
         if (h_cnt == 0) hin_seen[h_idx] <= {1'b0, bus.h_input};
         h_cnt <= h_cnt + 1;
         if (h_cnt + 1 == lh && !h_stall) begin
            bus.h_finish <= 1'b1;
            bus.h_output <= h_vals[h_idx];
            h_idx        <= h_idx + 1;
         end
      end
   end

   // Visible-layer stub: finish lv cycles after valid rises; logs the input it was given.
   always @(posedge clock) begin
      if (bus.rand_reset) begin
         v_idx <= 0;
         for (int i = 0; i < 16; i++) vin_seen[i] <= 16'hFFFF;
      end
      if (bus.v_layer_reset) begin
         v_cnt        <= 0;
         bus.v_finish <= 1'b0;
         bus.v_output <= '0;
      end else if (bus.v_data_valid && !bus.v_finish) begin
         if (v_cnt == 0) vin_seen[v_idx] <= {11'd0, bus.v_input};
         v_cnt <= v_cnt + 1;
         if (v_cnt + 1 == lv) begin
            bus.v_finish <= 1'b1;
            bus.v_output <= v_vals[v_idx];
            v_idx        <= v_idx + 1;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // One full run; cycle 1 is the cycle right after the accepting start edge.
   task automatic run_seq(input int steps, input logic [14:0] vin, input bit pulse_mid);
      int eff, p, done_cyc, done_cnt;
      eff      = (steps == 0) ? 1 : steps;
      p        = 2 + eff * ((lh + 1) + (lv + 1));
      done_cyc = 0;
      done_cnt = 0;
      @(negedge clock);
      bus.start     = 1'b1;
      bus.num_steps = 8'(steps);
      bus.v_in      = vin;
      @(posedge clock); #1;
      bus.start = 1'b0;
      for (int cyc = 1; cyc <= p + 4; cyc++) begin
         if (cyc == 1) begin
            check_eq("busy_rise", 32'(bus.busy), 32'd1);
            check_eq("error_clr", 32'(bus.error), 32'd0);
         end
         if (pulse_mid && cyc == 4) bus.start = 1'b1;
         if (pulse_mid && cyc == 5) bus.start = 1'b0;
         if (bus.done) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = cyc;
         end
         if (cyc == p) check_eq("busy_at_done", 32'(bus.busy), 32'd1);
         if (cyc == p + 1) check_eq("busy_fall", 32'(bus.busy), 32'd0);
         @(posedge clock); #1;
      end
      check_eq("done_cycle", 32'(done_cyc), 32'(p));
      check_eq("done_count", 32'(done_cnt), 32'd1);
      check_eq("v_out", 32'(bus.v_out), 32'(v_vals[eff-1]));
      check_eq("h_out", 32'(bus.h_out), 32'(h_vals[eff-1]));
      check_eq("h0_out", 32'(bus.h0_out), 32'(h_vals[0]));
      for (int k = 0; k < eff; k++) begin
         check_eq($sformatf("h_input_s%0d", k + 1), 32'(hin_seen[k]),
                  (k == 0) ? 32'(vin) : 32'(v_vals[k-1]));
         check_eq($sformatf("v_input_s%0d", k + 1), 32'(vin_seen[k]), 32'(h_vals[k]));
      end
   endtask

   task automatic randomize_vals();
      for (int i = 0; i < 16; i++) begin
         h_vals[i] = 5'($urandom);
         v_vals[i] = 15'($urandom);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "bench did not finish");
   end

   initial begin
      int done_seen;
      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.num_steps = '0;
      bus.v_in      = '0;
      h_stall       = 1'b0;
      lh            = 6;
      lv            = 6;
      randomize_vals();

      // Reset values.
      repeat (3) @(posedge clock);
      #1;
      check_eq("rst_rand_reset", 32'(bus.rand_reset), 32'd1);
      check_eq("rst_h_layer_reset", 32'(bus.h_layer_reset), 32'd1);
      check_eq("rst_v_layer_reset", 32'(bus.v_layer_reset), 32'd1);
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_done", 32'(bus.done), 32'd0);
      check_eq("rst_v_out", 32'(bus.v_out), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      check_eq("idle_rand_reset", 32'(bus.rand_reset), 32'd0);
      check_eq("idle_busy", 32'(bus.busy), 32'd0);

      // Single step, fixed stub outputs.
      h_vals[0] = 5'h15;
      v_vals[0] = 15'h0F0F;
      run_seq(1, 15'h1234, 1'b0);

      // Three steps with hidden outputs 1,2,3.
      randomize_vals();
      h_vals[0] = 5'h01;
      h_vals[1] = 5'h02;
      h_vals[2] = 5'h03;
      run_seq(3, 15'(($urandom)), 1'b0);

      // num_steps = 0 behaves as 1; a start pulse mid-run is ignored.
      randomize_vals();
      run_seq(0, 15'h7ABC, 1'b1);

      // Reset in the middle of V_RUN.
      randomize_vals();
      lh = 5;
      lv = 7;
      @(negedge clock);
      bus.start     = 1'b1;
      bus.num_steps = 8'd2;
      bus.v_in      = 15'h2222;
      @(posedge clock); #1;
      bus.start = 1'b0;
      for (int n = 0; n < 40 && !bus.v_data_valid; n++) begin
         @(posedge clock); #1;
      end
      check_eq("vrun_reached", 32'(bus.v_data_valid), 32'd1);
      reset = 1'b1;
      @(posedge clock); #1;
      check_eq("midrst_busy", 32'(bus.busy), 32'd0);
      check_eq("midrst_done", 32'(bus.done), 32'd0);
      check_eq("midrst_rand_reset", 32'(bus.rand_reset), 32'd1);
      check_eq("midrst_h_layer_reset", 32'(bus.h_layer_reset), 32'd1);
      check_eq("midrst_v_layer_reset", 32'(bus.v_layer_reset), 32'd1);
      check_eq("midrst_h_out", 32'(bus.h_out), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      done_seen = 0;
      repeat (6) begin
         @(posedge clock); #1;
         if (bus.done) done_seen++;
      end
      check_eq("midrst_no_done", 32'(done_seen), 32'd0);
      run_seq(2, 15'h1357, 1'b0);

`ifdef RBM_SEQ_TIMEOUT_EN
      // Hidden layer never finishes: watchdog fires, no done, next start clears error.
      begin
         int err_cyc;
         err_cyc   = 0;
         done_seen = 0;
         lh        = 6;
         lv        = 6;
         h_stall   = 1'b1;
         @(negedge clock);
         bus.start     = 1'b1;
         bus.num_steps = 8'd1;
         bus.v_in      = 15'h0101;
         @(posedge clock); #1;
         bus.start = 1'b0;
         for (int cyc = 1; cyc <= 30; cyc++) begin
            if (bus.error && err_cyc == 0) err_cyc = cyc;
            if (bus.done) done_seen++;
            @(posedge clock); #1;
         end
         check_eq("wd_error_cycle", 32'(err_cyc), 32'd22);
         check_eq("wd_no_done", 32'(done_seen), 32'd0);
         check_eq("wd_busy", 32'(bus.busy), 32'd0);
         check_eq("wd_h_layer_reset", 32'(bus.h_layer_reset), 32'd1);
         check_eq("wd_v_layer_reset", 32'(bus.v_layer_reset), 32'd1);
         h_stall = 1'b0;
         randomize_vals();
         run_seq(1, 15'h0F00, 1'b0);
      end
`endif

      // Randomized runs.
      for (int r = 0; r < 10; r++) begin
         randomize_vals();
         lh = $urandom_range(1, 8);
         lv = $urandom_range(1, 8);
         run_seq($urandom_range(0, 6), 15'($urandom), 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
